// File: rtl/leg_branch_pc_if.sv
// rtl/leg_branch_pc_if.sv - instruction handshake and PC status bundle for leg_branch_pc
interface leg_branch_pc_if #(
  parameter int PC_WIDTH = 8
);
  logic                instr_valid;
  logic                instr_ready;
  logic [7:0]          opcode;
  logic [PC_WIDTH-1:0] target;
  logic                cond_true;
  logic                stall;
  logic                pc_wr_en;
  logic [PC_WIDTH-1:0] pc_wr_data;
  logic [PC_WIDTH-1:0] pc;
  logic                flush;
  logic                branch_taken;
  logic [15:0]         taken_count;

  modport master (
    output instr_valid, opcode, target, cond_true, stall, pc_wr_en, pc_wr_data,
    input  instr_ready, pc, flush, branch_taken, taken_count
  );

  modport slave (
    input  instr_valid, opcode, target, cond_true, stall, pc_wr_en, pc_wr_data,
    output instr_ready, pc, flush, branch_taken, taken_count
  );
endinterface

// File: rtl/leg_branch_pc.sv
// rtl/leg_branch_pc.sv - program counter and branch resolution with post-redirect flush bubble
module leg_branch_pc #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  PC_STEP      = 4,
  parameter int                  FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  leg_branch_pc_if.slave   bus
);
  localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic                branch_taken_q, branch_taken_d;
  logic [15:0]         taken_count_q, taken_count_d;

  logic instr_ready;
  logic accept;
  logic is_cond;

  assign instr_ready = (state_q == RUN) && !bus.stall;
  assign accept      = bus.instr_valid && instr_ready;
  // Immediate flag bits [7:6] never affect branch classification.
  assign is_cond     = (bus.opcode[5:0] >= 6'h20) && (bus.opcode[5:0] <= 6'h29);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    flush_d        = flush_q;
    branch_taken_d = 1'b0;
    taken_count_d  = taken_count_q;

    if (state_q == FLUSH) begin
      if (cnt_q <= CW'(1)) begin
        state_d = RUN;
        flush_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // An external PC write wins and swallows any instruction accepted alongside it.
    if (bus.pc_wr_en) begin
      pc_d = bus.pc_wr_data;
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES);
        flush_d = 1'b1;
      end
    end else if (accept && is_cond && bus.cond_true) begin
      pc_d           = bus.target;
      branch_taken_d = 1'b1;
      if (taken_count_q != 16'hFFFF) begin
        taken_count_d = taken_count_q + 16'd1;
      end
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES);
        flush_d = 1'b1;
      end
    end else if (accept) begin
      pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      pc_q           <= RESET_PC;
      flush_q        <= 1'b0;
      branch_taken_q <= 1'b0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      flush_q        <= flush_d;
      branch_taken_q <= branch_taken_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign bus.instr_ready  = instr_ready;
  assign bus.pc           = pc_q;
  assign bus.flush        = flush_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.taken_count  = taken_count_q;
endmodule

// File: tb/tb_leg_branch_pc.sv
// tb/tb_leg_branch_pc.sv - directed self-checking bench for leg_branch_pc
module tb_leg_branch_pc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  leg_branch_pc_if #(.PC_WIDTH(8)) a_if ();
  leg_branch_pc_if #(.PC_WIDTH(8)) b_if ();

  leg_branch_pc #(.PC_WIDTH(8), .RESET_PC(8'h00), .PC_STEP(4), .FLUSH_CYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  // Bubble-free instance so the saturation run needs one cycle per taken branch.
  leg_branch_pc #(.PC_WIDTH(8), .RESET_PC(8'h00), .PC_STEP(4), .FLUSH_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] op, input logic [7:0] tgt,
                         input logic c, input logic st, input logic we, input logic [7:0] wd);
    a_if.instr_valid = v;
    a_if.opcode      = op;
    a_if.target      = tgt;
    a_if.cond_true   = c;
    a_if.stall       = st;
    a_if.pc_wr_en    = we;
    a_if.pc_wr_data  = wd;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] pc, input logic fl,
                       input logic bt, input logic [15:0] cnt);
    chk({tag, "_pc"},    32'(a_if.pc), 32'(pc));
    chk({tag, "_flush"}, 32'(a_if.flush), 32'(fl));
    chk({tag, "_bt"},    32'(a_if.branch_taken), 32'(bt));
    chk({tag, "_cnt"},   32'(a_if.taken_count), 32'(cnt));
  endtask

  initial begin
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    b_if.instr_valid = 0; b_if.opcode = 8'h00; b_if.target = 8'h00;
    b_if.cond_true = 0; b_if.stall = 0; b_if.pc_wr_en = 0; b_if.pc_wr_data = 8'h00;

    #3;
    chk_a("reset", 8'h00, 0, 0, 16'd0);
    tick();
    rst = 1'b1;
    chk("ready_after_reset", 32'(a_if.instr_ready), 32'd1);

    // Two fall-through accepts
    drive_a(1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("fall1", 8'h04, 0, 0, 16'd0);
    tick(); chk_a("fall2", 8'h08, 0, 0, 16'd0);

    // Taken branch at 0x08 to 0x40
    drive_a(1, 8'h20, 8'h40, 1, 0, 0, 8'h00);
    tick(); chk_a("br40", 8'h40, 1, 1, 16'd1);
    chk("br40_ready", 32'(a_if.instr_ready), 32'd0);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("br40_post", 8'h40, 0, 0, 16'd1);
    chk("br40_post_ready", 32'(a_if.instr_ready), 32'd1);

    // External write to 0x10, then flagged opcode 0xE5 not taken
    drive_a(0, 8'h00, 8'h00, 0, 0, 1, 8'h10);
    tick(); chk_a("wr10", 8'h10, 1, 0, 16'd1);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("wr10_post", 8'h10, 0, 0, 16'd1);
    drive_a(1, 8'hE5, 8'h70, 0, 0, 0, 8'h00);
    tick(); chk_a("e5_nt", 8'h14, 0, 0, 16'd1);

    // Class boundaries: 0x29 is a branch, 0x2A is not
    drive_a(1, 8'h29, 8'h60, 1, 0, 0, 8'h00);
    tick(); chk_a("op29", 8'h60, 1, 1, 16'd2);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick();
    drive_a(1, 8'h2A, 8'h20, 1, 0, 0, 8'h00);
    tick(); chk_a("op2a", 8'h64, 0, 0, 16'd2);

    // Write beats a simultaneous taken branch; write during flush reloads the bubble
    drive_a(1, 8'h21, 8'h40, 1, 0, 1, 8'h80);
    tick(); chk_a("wr_vs_br", 8'h80, 1, 0, 16'd2);
    drive_a(0, 8'h00, 8'h00, 0, 0, 1, 8'h84);
    tick(); chk_a("wr_in_flush", 8'h84, 1, 0, 16'd2);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("wr_in_flush_post", 8'h84, 0, 0, 16'd2);

    // Taken branch to pc+4 still counts and flushes
    drive_a(1, 8'h20, 8'h88, 1, 0, 0, 8'h00);
    tick(); chk_a("br_next", 8'h88, 1, 1, 16'd3);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick();

    // Wrap at 0xFC
    drive_a(0, 8'h00, 8'h00, 0, 0, 1, 8'hFC);
    tick();
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("at_fc", 8'hFC, 0, 0, 16'd3);
    drive_a(1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("wrap", 8'h00, 0, 0, 16'd3);

    // Stall holds pc for three cycles
    drive_a(1, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(a_if.pc), 32'h00);
      chk("stall_ready", 32'(a_if.instr_ready), 32'd0);
    end
    drive_a(1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    tick(); chk_a("unstall", 8'h04, 0, 0, 16'd3);

    // Async reset in the middle of a flush bubble
    drive_a(1, 8'h20, 8'h40, 1, 0, 0, 8'h00);
    tick(); chk_a("pre_rst", 8'h40, 1, 1, 16'd4);
    drive_a(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    #1 rst = 1'b0;
    #1 chk_a("rst_mid_flush", 8'h00, 0, 0, 16'd0);
    tick();
    rst = 1'b1;
    tick(); chk_a("after_rst", 8'h00, 0, 0, 16'd0);
    chk("after_rst_ready", 32'(a_if.instr_ready), 32'd1);

    // Saturation on the bubble-free instance
    b_if.instr_valid = 1; b_if.opcode = 8'h20; b_if.target = 8'h10; b_if.cond_true = 1;
    repeat (65534) tick();
    chk("sat_fffe", 32'(b_if.taken_count), 32'hFFFE);
    chk("sat_noflush", 32'(b_if.flush), 32'd0);
    tick(); chk("sat_ffff", 32'(b_if.taken_count), 32'hFFFF);
    tick(); chk("sat_hold", 32'(b_if.taken_count), 32'hFFFF);
    chk("sat_bt", 32'(b_if.branch_taken), 32'd1);
    b_if.instr_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
